// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg
// Shared types and constants for the data-memory arbiter slice.
//   dm_arb_state_t    : arbiter FSM state encoding
//   ARB_CPU/ARB_UART  : requester index into the request vector
//   DATA_W            : data-memory word width
//   starve_limit_u8() : folds the integer starvation limit into the
//                       8-bit counter range 1..255
package dm_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC_CPU,
    ACC_UART,
    DONE_CPU,
    DONE_UART
  } dm_arb_state_t;

  localparam int ARB_CPU  = 0;
  localparam int ARB_UART = 1;
  localparam int DATA_W   = 32;

  // The counter is 8 bits wide and a limit of 0 would make the UART win
  // every contested arbitration, so out-of-range values are clamped.
  function automatic logic [7:0] starve_limit_u8(input int limit);
    if (limit < 1) begin
      return 8'd1;
    end else if (limit > 255) begin
      return 8'd255;
    end else begin
      return 8'(limit);
    end
  endfunction

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// dm_arb_starve_ctr
// Saturating 8-bit wait counter that lets a starved UART requester beat
// the CPU in arbitration.
//   clk, reset : clock and asynchronous active-low reset
//   waiting    : UART has a request pending that is not being served
//   clear      : UART has just been granted
//   starved    : counter has reached LIMIT
module dm_arb_starve_ctr #(
  parameter logic [7:0] LIMIT = 8'd16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic clear,
  output logic starved
);

  logic [7:0] count;

  // Count waiting cycles up to LIMIT and hold there. A grant in the same
  // cycle as a waiting cycle takes priority so the count restarts at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (waiting && (count < LIMIT)) begin
      count <= count + 8'd1;
    end
  end

  assign starved = (count >= LIMIT);

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter
// Shares the single-port data memory between the CPU load/store path and
// the UART loader/dumper. Each side issues one-word req/ack transactions;
// the winner's address/we/data are registered onto the memory port, the
// memory is accessed for one cycle, and an ack pulse returns read data.
//
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata         CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata            CPU completion pulse and read data
//   cpu_stall                     cpu_req & ~cpu_ack, for the hazard unit
//   uart_req/we/addr/wdata        UART request (held until uart_ack)
//   uart_lock                     with uart_req, blocks CPU grants
//   uart_ack, uart_rdata          UART completion pulse and read data
//   mem_we/addr/wdata             registered memory port
//   mem_rdata                     asynchronous memory read data
//
// Build option: define DM_ARB_STARVE_GUARD_EN to compile in the starvation
// counter that lets a UART request waiting STARVE_LIMIT cycles win over
// the CPU. Without it, priority is fixed (CPU unless uart_lock).
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW           = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [AW-1:0]     uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  input  logic              uart_lock,
  output logic              uart_ack,
  output logic [DATA_W-1:0] uart_rdata,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] STARVE_LIMIT_U8 = starve_limit_u8(STARVE_LIMIT);

  dm_arb_state_t state;
  dm_arb_state_t next_state;
  logic [1:0]    req_vec;
  logic          grant_cpu;
  logic          grant_uart;
  logic          starved;

  assign req_vec[ARB_CPU]  = cpu_req;
  assign req_vec[ARB_UART] = uart_req;

`ifdef DM_ARB_STARVE_GUARD_EN
  // The UART counts as waiting whenever it requests and is not already
  // being served; idle IDLE cycles and CPU accesses both count.
  logic uart_waiting;

  assign uart_waiting = uart_req && (state != ACC_UART) && (state != DONE_UART);

  dm_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT_U8)
  ) u_starve_ctr (
    .clk     (clk),
    .reset   (reset),
    .waiting (uart_waiting),
    .clear   (grant_uart),
    .starved (starved)
  );
`else
  // Fixed priority: the limit is accepted for interface compatibility only.
  logic [7:0] unused_limit;

  assign unused_limit = STARVE_LIMIT_U8;
  assign starved      = 1'b0;
`endif

  // State register. Reset returns to IDLE immediately, which also kills
  // any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Arbitration and sequencing. Grants only happen in IDLE; the UART wins
  // a contested cycle when it holds the lock or has been starved.
  always_comb begin
    next_state = state;
    grant_cpu  = 1'b0;
    grant_uart = 1'b0;
    case (state)
      IDLE: begin
        if (req_vec[ARB_UART] && (!req_vec[ARB_CPU] || uart_lock || starved)) begin
          grant_uart = 1'b1;
          next_state = ACC_UART;
        end else if (req_vec[ARB_CPU]) begin
          grant_cpu  = 1'b1;
          next_state = ACC_CPU;
        end
      end
      ACC_CPU:   next_state = DONE_CPU;
      ACC_UART:  next_state = DONE_UART;
      DONE_CPU:  next_state = IDLE;
      DONE_UART: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Memory port registers. The winner's request is captured on the grant
  // edge so it is stable for the whole ACC cycle; the write enable is
  // cleared on every other edge so it is high only during ACC. Address and
  // data simply hold their last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_cpu) begin
      mem_we    <= cpu_we;
      mem_addr  <= cpu_addr;
      mem_wdata <= cpu_wdata;
    end else if (grant_uart) begin
      mem_we    <= uart_we;
      mem_addr  <= uart_addr;
      mem_wdata <= uart_wdata;
    end else begin
      mem_we    <= 1'b0;
    end
  end

  // Read data capture. The asynchronous memory output is sampled at the
  // end of the access cycle and held until the next access by that side.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata  <= '0;
      uart_rdata <= '0;
    end else begin
      if (state == ACC_CPU) begin
        cpu_rdata <= mem_rdata;
      end
      if (state == ACC_UART) begin
        uart_rdata <= mem_rdata;
      end
    end
  end

  assign cpu_ack   = (state == DONE_CPU);
  assign uart_ack  = (state == DONE_UART);
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
